vector_sweep_checker: RTL and testbench
=======================================

VECTOR_SWEEP_CHECKER -- requirements
Module: vector_sweep_checker

Interface
REQ-001 SHALL have parameter N_IN, default 3: number of bits in the input vector driven to both circuits under comparison (1..8).
REQ-002 SHALL have parameter SETTLE, default 1: idle cycles between a vector change and its compare (0..15).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset, sampled on rising clk.
REQ-005 SHALL have port start, input, 1 bit: request to begin a sweep.
REQ-006 SHALL have port vec, output, N_IN bits: the input vector driven to both circuits, registered.
REQ-007 SHALL have port qa, input, 1 bit: response of the reference (unsimplified) circuit.
REQ-008 SHALL have port qb, input, 1 bit: response of the candidate (simplified) circuit.
REQ-009 SHALL have port busy, output, 1 bit: high while a sweep is in progress.
REQ-010 SHALL have port done, output, 1 bit: high while a completed sweep's results are held.
REQ-011 SHALL have port pass, output, 1 bit: valid when done is high; 1 means no mismatch was found.
REQ-012 SHALL have port mismatch_cnt, output, N_IN+1 bits: number of vectors where qa != qb.
REQ-013 SHALL have port first_fail_vec, output, N_IN bits: lowest vector that mismatched.
REQ-014 SHALL have port first_fail_valid, output, 1 bit: high once any mismatch has been recorded.

Function
REQ-015 SHALL implement FSM states IDLE, SETTLE, COMPARE, DONE.
REQ-016 SHALL, in IDLE or DONE, on an edge with start=1: set vec to 0, clear mismatch_cnt, first_fail_vec and first_fail_valid, set busy=1 and done=0, and go to SETTLE; if SETTLE=0, go directly to COMPARE.
REQ-017 SHALL remain in SETTLE for exactly SETTLE cycles, counted by an internal counter, then go to COMPARE.
REQ-018 SHALL, in COMPARE (one cycle), evaluate qa != qb at the closing edge; on a mismatch, increment mismatch_cnt.
REQ-019 SHALL, on the first mismatch of a sweep, load first_fail_vec=vec and set first_fail_valid=1; later mismatches SHALL NOT change either.
REQ-020 SHALL, in COMPARE with vec < 2^N_IN-1, increment vec and return to SETTLE (or stay in COMPARE if SETTLE=0).
REQ-021 SHALL, in COMPARE with vec = 2^N_IN-1, go to DONE with busy=0, done=1, and pass = (final mismatch_cnt == 0), including a mismatch on this last vector; vec SHALL NOT wrap to 0.
REQ-022 SHALL take, from the edge accepting start, exactly 2^N_IN*(SETTLE+1) cycles until the edge that asserts done.
REQ-023 SHALL ignore start while busy=1.
REQ-024 SHALL hold all results and vec unchanged in DONE until a new start.
REQ-025 SHALL NOT saturate or wrap mismatch_cnt: N_IN+1 bits holds the maximum count of 2^N_IN.
REQ-026 SHALL drive pass low whenever done is low.

Reset
REQ-027 SHALL, on an edge with rst_n=0, set FSM=IDLE, vec=0, busy=0, done=0, pass=0, mismatch_cnt=0, first_fail_vec=0, first_fail_valid=0, and settle counter=0.
REQ-028 SHALL give reset priority over start and over any in-progress sweep; a reset mid-sweep discards partial results.

Structure
REQ-029 SHALL place the FSM state enumeration and the SETTLE counter width constant (4 bits) in a shared package, checker_pkg, reused by future checker blocks.
REQ-030 SHALL be a single module with no sub-modules; the circuits under comparison are instantiated externally alongside it, fed by vec and returning qa/qb.

Verification
REQ-031 SHALL be verified with N_IN=3, SETTLE=1, qa = a&b | (b&c)&(b|c), qb = b&(a|c), start pulsed one cycle -> done rises 16 cycles after start, pass=1, mismatch_cnt=0, first_fail_valid=0.
REQ-032 SHALL be verified with qb equal to qa except forced wrong at vec=5 -> mismatch_cnt=1, first_fail_vec=5, first_fail_valid=1, pass=0.
REQ-033 SHALL be verified with qb = ~qa and SETTLE=0 -> done 8 cycles after start, mismatch_cnt=8, first_fail_vec=0.
REQ-034 SHALL be verified with start re-pulsed while busy, at vec=2 -> no restart, and done still at cycle 16; start pulsed again in DONE -> results cleared and a full new sweep runs.
REQ-035 SHALL be verified with rst_n=0 for one edge while vec=3 -> next cycle all outputs are at reset values and FSM=IDLE; a subsequent start runs a clean 16-cycle sweep.

Source files
------------

// File: rtl/checker_pkg.sv
// Shared definitions for exhaustive-sweep equivalence checker blocks.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   SETTLE_CNT_W  width of the settle-delay counter (supports 0..15 idle cycles)
//   chk_state_e   sweep FSM states: idle, settle, compare, done
package checker_pkg;

   localparam int SETTLE_CNT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SETTLE  = 2'd1,
      ST_COMPARE = 2'd2,
      ST_DONE    = 2'd3
   } chk_state_e;

endpackage

// File: rtl/vector_sweep_checker.sv
// Drives every N_IN-bit vector to two external circuits and counts response mismatches.
// Latency: 2^N_IN*(SETTLE+1) cycles from the edge accepting start to the edge raising done.
// Backpressure: none; start is ignored while busy, results hold in DONE until the next start.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start             begin a sweep (accepted only when not busy)
//   vec               registered vector driven to both circuits
//   qa, qb            reference / candidate circuit responses
//   busy, done, pass  sweep status; pass is only ever high together with done
//   mismatch_cnt      number of vectors with qa != qb (never saturates)
//   first_fail_vec    lowest vector that mismatched, valid with first_fail_valid
module vector_sweep_checker #(
   parameter int N_IN   = 3,
   parameter int SETTLE = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   output logic [N_IN-1:0] vec,
   input  logic            qa,
   input  logic            qb,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [N_IN:0]   mismatch_cnt,
   output logic [N_IN-1:0] first_fail_vec,
   output logic            first_fail_valid
);

   import checker_pkg::*;

   localparam logic [N_IN-1:0]         VEC_LAST = {N_IN{1'b1}};
   localparam logic [N_IN-1:0]         VEC_ONE  = N_IN'(1);
   localparam logic [N_IN:0]           CNT_ONE  = (N_IN + 1)'(1);
   localparam logic [N_IN:0]           CNT_ZERO = '0;
   localparam logic [SETTLE_CNT_W-1:0] SET_ONE  = SETTLE_CNT_W'(1);
   // Counter value on the last settle cycle; unused when SETTLE is 0.
   localparam logic [SETTLE_CNT_W-1:0] SETTLE_LAST =
      SETTLE_CNT_W'((SETTLE > 0) ? (SETTLE - 1) : 0);
   // With no settle delay the sweep steps straight from one compare to the next.
   localparam chk_state_e STEP_STATE = (SETTLE == 0) ? ST_COMPARE : ST_SETTLE;

   chk_state_e              state_q, state_d;
   logic [SETTLE_CNT_W-1:0] settle_cnt_q, settle_cnt_d;
   logic [N_IN-1:0]         vec_q, vec_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    pass_q, pass_d;
   logic [N_IN:0]           mismatch_cnt_q, mismatch_cnt_d;
   logic [N_IN-1:0]         first_fail_vec_q, first_fail_vec_d;
   logic                    first_fail_valid_q, first_fail_valid_d;

   logic                    mismatch;
   logic [N_IN:0]           cnt_after_cmp;

   always_comb begin
      state_d            = state_q;
      settle_cnt_d       = settle_cnt_q;
      vec_d              = vec_q;
      busy_d             = busy_q;
      done_d             = done_q;
      pass_d             = pass_q;
      mismatch_cnt_d     = mismatch_cnt_q;
      first_fail_vec_d   = first_fail_vec_q;
      first_fail_valid_d = first_fail_valid_q;

      mismatch      = (qa != qb);
      // Count including the vector under compare; pass on the final vector
      // must see a mismatch found on that same edge.
      cnt_after_cmp = mismatch ? (mismatch_cnt_q + CNT_ONE) : mismatch_cnt_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               vec_d              = '0;
               settle_cnt_d       = '0;
               mismatch_cnt_d     = '0;
               first_fail_vec_d   = '0;
               first_fail_valid_d = 1'b0;
               busy_d             = 1'b1;
               done_d             = 1'b0;
               pass_d             = 1'b0;
               state_d            = STEP_STATE;
            end
         end

         ST_SETTLE: begin
            if (settle_cnt_q == SETTLE_LAST) begin
               settle_cnt_d = '0;
               state_d      = ST_COMPARE;
            end else begin
               settle_cnt_d = settle_cnt_q + SET_ONE;
            end
         end

         ST_COMPARE: begin
            mismatch_cnt_d = cnt_after_cmp;
            // Only the first mismatch of a sweep is captured; vectors rise
            // monotonically so this is also the lowest failing vector.
            if (mismatch && !first_fail_valid_q) begin
               first_fail_vec_d   = vec_q;
               first_fail_valid_d = 1'b1;
            end
            if (vec_q == VEC_LAST) begin
               // vec stays on the last vector so the failing stimulus is visible.
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = (cnt_after_cmp == CNT_ZERO);
               state_d = ST_DONE;
            end else begin
               vec_d   = vec_q + VEC_ONE;
               state_d = STEP_STATE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q            <= ST_IDLE;
         settle_cnt_q       <= '0;
         vec_q              <= '0;
         busy_q             <= 1'b0;
         done_q             <= 1'b0;
         pass_q             <= 1'b0;
         mismatch_cnt_q     <= '0;
         first_fail_vec_q   <= '0;
         first_fail_valid_q <= 1'b0;
      end else begin
         state_q            <= state_d;
         settle_cnt_q       <= settle_cnt_d;
         vec_q              <= vec_d;
         busy_q             <= busy_d;
         done_q             <= done_d;
         pass_q             <= pass_d;
         mismatch_cnt_q     <= mismatch_cnt_d;
         first_fail_vec_q   <= first_fail_vec_d;
         first_fail_valid_q <= first_fail_valid_d;
      end
   end

   assign vec              = vec_q;
   assign busy             = busy_q;
   assign done             = done_q;
   assign pass             = pass_q;
   assign mismatch_cnt     = mismatch_cnt_q;
   assign first_fail_vec   = first_fail_vec_q;
   assign first_fail_valid = first_fail_valid_q;

endmodule

// File: tb/tb_vector_sweep_checker.sv
// Self-checking bench: two checker instances (SETTLE=1 and SETTLE=0) sweep a
// 3-input circuit pair whose candidate response comes from a truth table.
module tb_vector_sweep_checker;

   import checker_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start1, start0;
   logic [2:0] vec1, vec0;
   logic       qa1, qb1, qa0, qb0;
   logic       busy1, done1, pass1, ffval1;
   logic       busy0, done0, pass0, ffval0;
   logic [3:0] cnt1, cnt0;
   logic [2:0] ffv1, ffv0;

   logic [7:0] tab;       // candidate response, indexed by vector
   logic [7:0] ref_tab;   // reference response, indexed by vector

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   vector_sweep_checker #(.N_IN(3), .SETTLE(1)) dut (
      .clk(clk), .rst_n(rst_n), .start(start1), .vec(vec1), .qa(qa1), .qb(qb1),
      .busy(busy1), .done(done1), .pass(pass1), .mismatch_cnt(cnt1),
      .first_fail_vec(ffv1), .first_fail_valid(ffval1)
   );

   vector_sweep_checker #(.N_IN(3), .SETTLE(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .vec(vec0), .qa(qa0), .qb(qb0),
      .busy(busy0), .done(done0), .pass(pass0), .mismatch_cnt(cnt0),
      .first_fail_vec(ffv0), .first_fail_valid(ffval0)
   );

   function automatic logic ref_fn(input logic [2:0] v);
      logic a, b, c;
      a = v[2]; b = v[1]; c = v[0];
      return (a & b) | ((b & c) & (b | c));
   endfunction

   always_comb begin
      qa1 = ref_fn(vec1);
      qb1 = tab[vec1];
      qa0 = ref_fn(vec0);
      qb0 = tab[vec0];
   end

   // Observation mux: sel=1 looks at the SETTLE=0 instance.
   bit         sel;
   logic       o_busy, o_done, o_pass, o_ffval;
   logic [3:0] o_cnt;
   logic [2:0] o_vec, o_ffv;
   always_comb begin
      o_busy  = sel ? busy0  : busy1;
      o_done  = sel ? done0  : done1;
      o_pass  = sel ? pass0  : pass1;
      o_ffval = sel ? ffval0 : ffval1;
      o_cnt   = sel ? cnt0   : cnt1;
      o_vec   = sel ? vec0   : vec1;
      o_ffv   = sel ? ffv0   : ffv1;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   // Expected results straight from the truth tables.
   task automatic model(input logic [7:0] t, output int cnt, output int ff, output bit val);
      cnt = 0; ff = 0; val = 0;
      for (int v = 0; v < 8; v++) begin
         if (t[v] != ref_tab[v]) begin
            cnt++;
            if (!val) begin ff = v; val = 1; end
         end
      end
   endtask

   task automatic set_start(input bit s, input logic v);
      if (s) start0 = v; else start1 = v;
   endtask

   task automatic check_reset_vals(input string tag);
      check_eq({tag, ".busy"},  o_busy,  0);
      check_eq({tag, ".done"},  o_done,  0);
      check_eq({tag, ".pass"},  o_pass,  0);
      check_eq({tag, ".cnt"},   o_cnt,   0);
      check_eq({tag, ".ffv"},   o_ffv,   0);
      check_eq({tag, ".ffval"}, o_ffval, 0);
      check_eq({tag, ".vec"},   o_vec,   0);
   endtask

   // One sweep; optionally re-pulse start while busy when vec reaches repulse_at.
   task automatic run_sweep(input bit s, input string tag, input int repulse_at);
      int  lat, exp_lat, e_cnt, e_ff;
      bit  e_val, repulsed;
      sel = s;
      exp_lat = s ? 8 : 16;
      @(negedge clk);
      set_start(s, 1'b1);
      @(posedge clk); #1;
      set_start(s, 1'b0);
      check_eq({tag, ".acc_busy"},  o_busy,  1);
      check_eq({tag, ".acc_done"},  o_done,  0);
      check_eq({tag, ".acc_cnt"},   o_cnt,   0);
      check_eq({tag, ".acc_ffval"}, o_ffval, 0);
      check_eq({tag, ".acc_vec"},   o_vec,   0);
      lat = 0; repulsed = 0;
      while (lat < 200) begin
         @(posedge clk); lat++; #1;
         if (o_done) break;
         if (o_pass) check_eq({tag, ".pass_while_busy"}, o_pass, 0);
         if (!repulsed && repulse_at >= 0 && int'(o_vec) == repulse_at) begin
            set_start(s, 1'b1);
            repulsed = 1;
         end else begin
            set_start(s, 1'b0);
         end
      end
      set_start(s, 1'b0);
      check_eq({tag, ".latency"}, lat, exp_lat);
      model(tab, e_cnt, e_ff, e_val);
      check_eq({tag, ".cnt"},   o_cnt,   e_cnt);
      check_eq({tag, ".ffv"},   o_ffv,   e_ff);
      check_eq({tag, ".ffval"}, o_ffval, e_val);
      check_eq({tag, ".pass"},  o_pass,  (e_cnt == 0) ? 1 : 0);
      check_eq({tag, ".busy"},  o_busy,  0);
      check_eq({tag, ".vec"},   o_vec,   7);
   endtask

   initial begin
      int e_cnt, e_ff, lat;
      bit e_val;
      for (int v = 0; v < 8; v++) ref_tab[v] = ref_fn(3'(v));
      tab    = ref_tab;
      rst_n  = 1'b0;
      start1 = 1'b0;
      start0 = 1'b0;
      sel    = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      sel = 0; check_reset_vals("rst1");
      sel = 1; check_reset_vals("rst0");
      rst_n = 1'b1;

      // Simplified circuit equals the reference.
      tab = ref_tab;
      run_sweep(0, "equiv", -1);

      // Candidate wrong only at vector 5.
      tab = ref_tab ^ 8'h20;
      run_sweep(0, "force5", -1);

      // Mismatch on the last vector only.
      tab = ref_tab ^ 8'h80;
      run_sweep(0, "force7", -1);

      // Inverted candidate, no settle delay.
      tab = ~ref_tab;
      run_sweep(1, "invert", -1);

      // Start re-pulsed mid-sweep is ignored.
      tab = ref_tab ^ 8'h0a;
      run_sweep(0, "repulse", 2);
      model(tab, e_cnt, e_ff, e_val);
      repeat (5) @(posedge clk);
      #1;
      check_eq("hold.done", o_done, 1);
      check_eq("hold.vec",  o_vec,  7);
      check_eq("hold.cnt",  o_cnt,  e_cnt);
      check_eq("hold.ffv",  o_ffv,  e_ff);

      // Start in DONE clears and reruns.
      tab = ref_tab;
      run_sweep(0, "restart", -1);

      // Reset while vec=3.
      tab = ref_tab ^ 8'h03;
      sel = 0;
      @(negedge clk);
      start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      lat = 0;
      while (lat < 100 && o_vec != 3'd3) begin
         @(posedge clk); lat++; #1;
      end
      check_eq("midrst.reach_vec3", o_vec, 3);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check_reset_vals("midrst");
      check_eq("midrst.state", dut.state_q, ST_IDLE);
      repeat (3) @(posedge clk);
      #1;
      check_eq("midrst.idle_busy", o_busy, 0);
      tab = ref_tab ^ 8'h40;
      run_sweep(0, "postrst", -1);

      // Randomized candidate tables on both instances.
      for (int i = 0; i < 8; i++) begin
         tab = 8'($urandom);
         run_sweep(i[0], $sformatf("rand%0d", i), -1);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
